grant_capture_mux: RTL and testbench
====================================

Name: grant_capture_mux

Overview:
- Sits directly downstream of the one-hot round-robin arbiter (N requesters, registered one-hot grant pulse).
- Generates the arbiter's req vector from per-channel valid/data sources and uses the returned one-hot grant to select the granted channel's word.
- Acks the source and writes the word plus source index into a small output FIFO with valid/ready.
- Gates requests by FIFO credit so a granted word is never dropped.

Parameters:
- N, 4, number of channels (>=2; must match arbiter N).
- W, 32, data width per channel.
- DEPTH, 4, output FIFO depth (power of two, >=2).
- SRC_W, $clog2(N), width of source index (derived localparam).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  N  per-channel word valid; held until matching s_ack.
- s_data  in  N*W  channel i occupies bits [i*W +: W].
- s_ack  out  N  one-hot; s_ack[i]=1 in the cycle channel i's word is captured.
- arb_req  out  N  request vector to arbiter.
- arb_grant  in  N  registered one-hot grant from arbiter; at most one bit set, never two consecutive cycles.
- m_valid  out  1  FIFO head valid.
- m_data  out  W  FIFO head data.
- m_src  out  SRC_W  channel index of head word.
- m_ready  in  1  consumer accepts head when m_valid&m_ready.
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): FIFO empty, count=0, m_valid=0, m_data=0, m_src=0, err=0. arb_req=0 because count logic is reset and s_valid is gated. Release takes effect on the next clk edge.
- Credit: space_ok = (count + |arb_grant) < DEPTH. Here count is the current occupancy and |arb_grant accounts for the grant in flight.
- Request path: arb_req = s_valid & ~arb_grant & {N{space_ok}}. This is combinational; the arbiter registers it.
  - Masking the currently granted channel prevents a stale re-request while its source drops valid.
- Capture:
  - s_ack = arb_grant & s_valid (combinational).
  - When |s_ack, at the clk edge, push {idx(s_ack), s_data[idx*W +: W]}.
  - idx is the encoded index of the set bit, lowest index if more than one bit is set.
  - Latency: arb_req high at edge t -> grant visible cycle t+1 -> push at edge t+2 -> m_valid high cycle t+2 if FIFO was empty.
- Source rule: on seeing s_ack[i]=1 at an edge, the source presents its next word or drops s_valid[i] from that edge.
- FIFO behaviour:
  - First-word-fall-through; m_data/m_src are the registered head entry.
  - Pop on m_valid&m_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Push when full cannot occur given the credit rule; if it does, the word is dropped and err is set (macro on).
  - Pointers wrap modulo DEPTH.
- Grant with s_valid[idx]=0 (spurious grant): no push, no ack; err set (macro on).
- Reset mid-operation: all buffered words are discarded. Sources see no ack for in-flight grants and must re-request.
- No internal arbitration: fairness comes entirely from the arbiter.

Optional Feature:
- Macro GRANT_CAPTURE_MUX_ERR_EN.
- Defined:
  - err is a sticky register, set on any of: arb_grant not one-hot-or-zero, spurious grant, push when full.
  - Cleared only by reset.
- Undefined:
  - Checking logic is not built and err is tied 0.
  - Multi-bit grant still selects the lowest index.

Decomposition:
- Shared package/header: SRC_W derivation function (clog2) and the one-hot-to-index encode function. These are reused by other arbiter clients.
- One natural sub-module: grant_capture_fifo.
  - Parameters W+SRC_W, DEPTH.
  - Ports: push, push_data, pop, head_data, head_valid, count, full.
  - Same async active-low reset.

Test Plan:
- Single request: N=4, s_valid=4'b0100, data 0xA5A5_0002, m_ready=1 -> arb_req=4'b0100; grant cycle t+1 with s_ack=4'b0100; m_valid cycle t+2, m_data=0xA5A5_0002, m_src=2.
- All channels valid continuously, m_ready=1 -> m_src sequence 0,1,2,3,0,... Exactly one push every two cycles, no duplicates, each s_ack one cycle wide.
- Backpressure: m_ready=0, all valid, DEPTH=4 -> exactly 4 pushes, then arb_req=0 while count=4. Raising m_ready drains in order and requests resume; err stays 0.
- Push and pop in the same cycle at count=3 -> count stays 3, head advances, order intact.
- Spurious grant: force arb_grant=4'b1000 with s_valid[3]=0 -> no push, s_ack=0. err=1 with GRANT_CAPTURE_MUX_ERR_EN, err=0 without.
- Reset asserted asynchronously with 2 words queued mid-clock -> m_valid=0, err=0, arb_req=0 immediately. After release, fresh requests behave as in the single-request scenario.

Source files
------------

// File: rtl/grant_capture_mux_pkg.sv
// Shared helpers for clients of the one-hot round-robin arbiter:
// width derivation, one-hot to index encoding and the error-cause record.
package grant_capture_mux_pkg;

  // Widest request vector the shared encoder accepts
  localparam int MAX_CH = 64;

  // Causes that can raise the sticky protocol error flag
  typedef struct packed {
    logic multi_grant;  // grant vector had more than one bit set
    logic spurious;     // grant arrived for a channel with no valid word
    logic overflow;     // a capture arrived while the FIFO was full
  } err_cause_t;

  // Ceiling log2, never below 1 so that derived index fields stay non-empty
  function automatic int clog2_f(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Index of the lowest set bit; zero when no bit is set
  function automatic logic [5:0] onehot_to_idx(input logic [MAX_CH-1:0] vec);
    logic [5:0] idx;
    logic       found;
    idx   = 6'd0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (vec[i] && !found) begin
        idx   = 6'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_capture_fifo.sv
// First-word-fall-through FIFO holding captured {source index, data} entries.
// The head entry is read straight out of the storage registers; a push into a
// full FIFO is dropped and a pop from an empty FIFO is ignored.
module grant_capture_fifo
  import grant_capture_mux_pkg::*;
#(
  parameter  int DW    = 34,
  parameter  int DEPTH = 4,
  localparam int CNT_W = clog2_f(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int              PTR_W  = clog2_f(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [DW-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full       = (count_r == FULL_C);
  assign head_valid = (count_r != {CNT_W{1'b0}});
  assign do_push_s  = push & ~full;
  assign do_pop_s   = pop & head_valid;
  assign head_data  = mem_r[rd_ptr_r];
  assign count      = count_r;

  // Storage write and pointer advance; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy tracking; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/grant_capture_mux.sv
// Client-side glue for the one-hot round-robin arbiter: builds the request
// vector from per-channel valid/data sources, captures the granted channel's
// word into an output FIFO, acks the source, and throttles requests by FIFO
// credit so that a granted word always has room.
// Optional protocol checking is built when GRANT_CAPTURE_MUX_ERR_EN is defined;
// otherwise err is tied low.
module grant_capture_mux
  import grant_capture_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int SRC_W = clog2_f(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     s_valid,
  input  logic [N*W-1:0]   s_data,
  output logic [N-1:0]     s_ack,
  output logic [N-1:0]     arb_req,
  input  logic [N-1:0]     arb_grant,
  output logic             m_valid,
  output logic [W-1:0]     m_data,
  output logic [SRC_W-1:0] m_src,
  input  logic             m_ready,
  output logic             err
);

  localparam int               CNT_W   = clog2_f(DEPTH + 1);
  localparam int               EW      = W + SRC_W;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic                run_r;
  logic                grant_any_s;
  logic [N-1:0]        grant_low_s;
  logic [MAX_CH-1:0]   grant_ext_s;
  logic [SRC_W-1:0]    idx_s;
  logic [W-1:0]        sel_data_s;
  logic                space_ok_s;
  logic                ack_any_s;
  logic                push_s;
  logic                full_s;
  logic                head_valid_s;
  logic [CNT_W-1:0]    count_s;
  logic [EW-1:0]       head_s;

  // Requests and acks stay quiet from reset assertion until the first edge
  // after release, so in-flight grants around a reset are never acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Grant decode: a multi-bit grant resolves to its lowest channel
  assign grant_any_s = |arb_grant;
  assign grant_low_s = arb_grant & (~arb_grant + {{(N-1){1'b0}}, 1'b1});
  assign grant_ext_s = {{(MAX_CH-N){1'b0}}, arb_grant};
  assign idx_s       = SRC_W'(onehot_to_idx(grant_ext_s));
  assign sel_data_s  = s_data[int'(idx_s) * W +: W];

  // Credit counts the grant already in flight so the word it brings has room
  assign space_ok_s = ({1'b0, count_s} + {{CNT_W{1'b0}}, grant_any_s}) < DEPTH_C;

  // The granted channel is masked so it cannot re-request while its source
  // is still dropping or replacing the word just captured.
  assign arb_req = s_valid & ~arb_grant & {N{space_ok_s & run_r}};

  assign s_ack     = grant_low_s & s_valid & {N{run_r}};
  assign ack_any_s = |s_ack;
  assign push_s    = ack_any_s & ~full_s;

  grant_capture_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_data  ({idx_s, sel_data_s}),
    .pop        (m_ready),
    .head_data  (head_s),
    .head_valid (head_valid_s),
    .count      (count_s),
    .full       (full_s)
  );

  assign m_valid = head_valid_s;
  assign m_data  = head_s[W-1:0];
  assign m_src   = head_s[EW-1:W];

`ifdef GRANT_CAPTURE_MUX_ERR_EN
  err_cause_t cause_s;
  logic       err_r;

  // Classify arbiter/FIFO protocol violations visible this cycle
  always_comb begin
    cause_s             = '0;
    cause_s.multi_grant = |(arb_grant & ~grant_low_s);
    cause_s.spurious    = grant_any_s & ~(|(grant_low_s & s_valid));
    cause_s.overflow    = ack_any_s & full_s;
  end

  // Sticky error flag; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (run_r && (|cause_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_grant_capture_mux.sv
// Randomized bench for grant_capture_mux with a queue-based reference model
// and a behavioural round-robin arbiter that never grants two cycles in a row.
module tb_grant_capture_mux;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int SRC_W = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     s_valid;
  logic [N*W-1:0]   s_data;
  logic [N-1:0]     s_ack;
  logic [N-1:0]     arb_req;
  logic [N-1:0]     arb_grant;
  logic             m_valid;
  logic [W-1:0]     m_data;
  logic [SRC_W-1:0] m_src;
  logic             m_ready;
  logic             err;

  grant_capture_mux #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ack     (s_ack),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_src     (m_src),
    .m_ready   (m_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [W-1:0]     data;
  } ent_t;

  // Reference state: pending words per source, expected output order
  logic [W-1:0] src_q [N][$];
  ent_t         out_q [$];
  logic [N-1:0] grant_m;
  logic [N-1:0] force_grant;
  logic [N-1:0] gen_en;
  int           rr_ptr;
  int           ready_mode;   // 0 random, 1 held low, 2 held high
  int           gen_pct;
  bit           run_m;
  bit           err_m;
  int unsigned  seq;

  logic [N-1:0]     obs_req;
  logic [N-1:0]     obs_ack;
  logic             obs_mvalid;
  logic [W-1:0]     obs_mdata;
  logic [SRC_W-1:0] obs_msrc;
  int               acks_seen;

  int checks;
  int failures;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (src_q[i].size() > 0);
    return v;
  endfunction

  function automatic int low_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Request only what can be stored: buffered words plus the grant in flight
  function automatic logic [N-1:0] exp_req();
    int occ;
    occ = out_q.size() + ((grant_m != '0) ? 1 : 0);
    if (!run_m || occ >= DEPTH) return '0;
    return exp_valid() & ~grant_m;
  endfunction

  function automatic logic [N-1:0] exp_ack();
    logic [N-1:0] one;
    int k;
    one = 1;
    if (!run_m || grant_m == '0) return '0;
    k = low_idx(grant_m);
    if (src_q[k].size() == 0) return '0;
    return one << k;
  endfunction

  function automatic logic exp_err();
`ifdef GRANT_CAPTURE_MUX_ERR_EN
    return err_m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      s_valid[i] = (src_q[i].size() > 0);
      s_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : W'($urandom);
    end
    arb_grant = grant_m;
    m_ready   = (ready_mode == 0) ? 1'($urandom_range(1)) : (ready_mode == 2);
  endtask

  task automatic cycle();
    logic [N-1:0] er;
    logic [N-1:0] ea;
    ent_t         e;
    bit           ovf;
    int           k;
    @(negedge clk);
    er = exp_req();
    ea = exp_ack();
    check_val("arb_req", arb_req, er);
    check_val("s_ack", s_ack, ea);
    check_val("m_valid", m_valid, out_q.size() > 0);
    if (out_q.size() > 0) begin
      e = out_q[0];
      check_val("m_data", m_data, e.data);
      check_val("m_src", m_src, e.src);
    end
    check_val("err", err, exp_err());
    obs_req = arb_req; obs_ack = s_ack; obs_mvalid = m_valid;
    obs_mdata = m_data; obs_msrc = m_src;
    if (|s_ack) acks_seen++;
    @(posedge clk);
    ovf = (ea != '0) && (out_q.size() >= DEPTH);
    if (run_m) begin
      if ($countones(grant_m) > 1) err_m = 1'b1;
      if (grant_m != '0 && ea == '0) err_m = 1'b1;
      if (ovf) err_m = 1'b1;
    end
    if (out_q.size() > 0 && m_ready) void'(out_q.pop_front());
    if (ea != '0) begin
      k = low_idx(ea);
      e.src  = SRC_W'(k);
      e.data = src_q[k][0];
      if (!ovf) out_q.push_back(e);
      void'(src_q[k].pop_front());
    end
    if (force_grant != '0) begin
      grant_m = force_grant;
    end else if (grant_m != '0) begin
      grant_m = '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        k = (rr_ptr + j) % N;
        if (er[k]) begin
          grant_m[k] = 1'b1;
          rr_ptr = (k + 1) % N;
          break;
        end
      end
    end
    run_m = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      if (gen_en[i] && src_q[i].size() < 3 && $urandom_range(99) < gen_pct) begin
        seq++;
        src_q[i].push_back({8'(i), seq[23:0]});
      end
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_q.delete();
    grant_m = '0; rr_ptr = 0; run_m = 1'b0; err_m = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    run_m = 1'b1;
    #1;
    drive_inputs();
  endtask

  task automatic single_req();
    gen_en = '0; ready_mode = 2;
    for (int i = 0; i < N; i++) src_q[i].delete();
    src_q[2].push_back(32'hA5A5_0002);
    do_reset();
    cycle(); check_val("sr_req", obs_req, 4'b0100);
    cycle(); check_val("sr_ack", obs_ack, 4'b0100);
    cycle();
    check_val("sr_mvalid", obs_mvalid, 1'b1);
    check_val("sr_mdata", obs_mdata, 32'hA5A5_0002);
    check_val("sr_msrc", obs_msrc, 2'd2);
  endtask

  task automatic drain();
    gen_en = '0; ready_mode = 2;
    repeat (30) cycle();
  endtask

  initial begin
    bit   found;
    ent_t nxt;
    checks = 0; failures = 0;
    rst_n = 1'b0; s_valid = '0; s_data = '0; arb_grant = '0; m_ready = 1'b0;
    grant_m = '0; force_grant = '0; gen_en = '0; gen_pct = 0; ready_mode = 2;
    rr_ptr = 0; run_m = 1'b0; err_m = 1'b0; seq = 0; acks_seen = 0;
    src_q[2].push_back(32'h1234_5678);
    drive_inputs();
    #2;
    check_val("rst_mvalid", m_valid, 1'b0);
    check_val("rst_mdata", m_data, 32'h0);
    check_val("rst_msrc", m_src, 2'd0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_req", arb_req, 4'b0000);

    // Single request latency
    single_req();

    // All channels valid: one capture every two cycles
    gen_en = '1; gen_pct = 100; ready_mode = 2;
    repeat (6) cycle();
    acks_seen = 0;
    repeat (16) cycle();
    check_val("rr_rate", acks_seen, 8);

    // Backpressure: FIFO fills to DEPTH then requests stop
    drain();
    acks_seen = 0;
    gen_en = '1; gen_pct = 100; ready_mode = 1;
    repeat (24) cycle();
    check_val("bp_pushes", acks_seen, DEPTH);
    ready_mode = 2;
    repeat (30) cycle();
    check_val("bp_resume", acks_seen > 2 * DEPTH, 1'b1);

    // Push and pop in the same cycle at count 3
    drain();
    gen_en = '1; gen_pct = 100; ready_mode = 1;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      cycle();
      if (out_q.size() == 3 && exp_ack() != '0) found = 1'b1;
    end
    check_val("pp_setup", found, 1'b1);
    nxt = out_q[1];
    m_ready = 1'b1;
    cycle();
    cycle();
    check_val("pp_head_data", obs_mdata, nxt.data);
    check_val("pp_head_src", obs_msrc, nxt.src);

    // Spurious grant on an idle channel
    drain();
    force_grant = 4'b1000;
    cycle();
    force_grant = '0;
    cycle();
    check_val("spur_ack", obs_ack, 4'b0000);
    check_val("spur_mvalid", obs_mvalid, 1'b0);
    cycle();
`ifdef GRANT_CAPTURE_MUX_ERR_EN
    check_val("spur_err", err, 1'b1);
`else
    check_val("spur_err", err, 1'b0);
`endif

    // Asynchronous reset with two words queued
    gen_en = '1; gen_pct = 100; ready_mode = 1;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      cycle();
      if (out_q.size() == 2) found = 1'b1;
    end
    check_val("ar_setup", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_mvalid", m_valid, 1'b0);
    check_val("ar_err", err, 1'b0);
    check_val("ar_req", arb_req, 4'b0000);
    check_val("ar_mdata", m_data, 32'h0);
    single_req();

    // Randomized traffic
    gen_en = '1; gen_pct = 40; ready_mode = 0;
    repeat (400) cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
